// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: inputs latched once per frame,
// dead time at the start of every digit slot, per-digit blank, decimal point and blink.
module seg_scan_driver #(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned SCAN_DIV     = 100000,
   parameter int unsigned DEAD         = 2000,
   parameter int unsigned BLINK_FRAMES = 50
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   digits,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [DIGITS-1:0]     blink,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  seg_dp,
   output logic                  frame_done
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(DIGITS);
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [FRM_W-1:0]    frame_cnt;
   logic                blink_phase;

   logic [4*DIGITS-1:0] sh_digits;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_blank;
   logic [DIGITS-1:0]   sh_blink;

   logic                slot_end;
   logic                frame_end;
   logic [3:0]          nib;
   logic                cur_dp;
   logic                cur_blank;
   logic                cur_blink;
   logic                dark;
   logic [DIGITS-1:0]   an_nxt;
   logic [6:0]          seg_nxt;
   logic                dp_nxt;

   function automatic logic [6:0] decode(input logic [3:0] v);
      decode = 7'h7F;
      case (v)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         4'hF: decode = 7'h0E;
         default: decode = 7'h7F;
      endcase
   endfunction

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + 1'b1;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (frame_end) begin
            if (frame_cnt == FRM_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Blank resets to all ones so the first frame after reset stays dark.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_digits <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         sh_blink  <= '0;
      end else if (frame_end) begin
         sh_digits <= digits;
         sh_dp     <= dp;
         sh_blank  <= blank;
         sh_blink  <= blink;
      end
   end

   always_comb begin
      nib       = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      an_nxt    = '1;
      seg_nxt   = '1;
      dp_nxt    = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            nib       = sh_digits[4*i +: 4];
            cur_dp    = sh_dp[i];
            cur_blank = sh_blank[i];
            cur_blink = sh_blink[i];
         end
      end
      dark = (cnt < CNT_DEAD) || cur_blank || (cur_blink && blink_phase);
      if (!dark) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i))
               an_nxt[i] = 1'b0;
         end
         seg_nxt = decode(nib);
         dp_nxt  = ~cur_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= '1;
         seg        <= '1;
         seg_dp     <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= seg_nxt;
         seg_dp     <= dp_nxt;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2.
module tb_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [3:0]  blink;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        seg_dp;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_scan_driver #(
      .DIGITS       (4),
      .SCAN_DIV     (4),
      .DEAD         (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp         (dp),
      .blank      (blank),
      .blink      (blink),
      .an         (an),
      .seg        (seg),
      .seg_dp     (seg_dp),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output after the k-th edge of a frame reflects slot k/4, cnt k%4 of that frame.
   task automatic check_span(input int k0, input int k1, input logic [27:0] segs,
                             input logic [3:0] lit, input logic [3:0] dpn);
      for (int k = k0; k <= k1; k++) begin
         int         slot;
         logic [3:0] exp_an;
         tick();
         slot = k / 4;
         if ((k % 4) == 0 || !lit[slot]) begin
            check("an_dark",  32'(an),     32'(4'hF));
            check("seg_dark", 32'(seg),    32'(7'h7F));
            check("dp_dark",  32'(seg_dp), 32'(1'b1));
         end else begin
            exp_an       = 4'hF;
            exp_an[slot] = 1'b0;
            check("an_lit",  32'(an),     32'(exp_an));
            check("seg_lit", 32'(seg),    32'(segs[slot*7 +: 7]));
            check("dp_lit",  32'(seg_dp), 32'(dpn[slot]));
         end
         check("frame_done", 32'(frame_done), 32'(k == 15));
      end
   endtask

   task automatic check_frame(input logic [27:0] segs, input logic [3:0] lit, input logic [3:0] dpn);
      check_span(0, 15, segs, lit, dpn);
   endtask

   initial begin
      logic [27:0] exp_segs;
      logic [3:0]  exp_dpn;
      logic [3:0]  blink_lit [6] = '{4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b1101, 4'b1101};

      rst_n  = 1'b0;
      digits = 16'h1234;
      dp     = 4'h0;
      blank  = 4'h0;
      blink  = 4'h0;
      repeat (3) tick();
      check("rst_an",    32'(an),         32'(4'hF));
      check("rst_seg",   32'(seg),        32'(7'h7F));
      check("rst_dp",    32'(seg_dp),     32'(1'b1));
      check("rst_fdone", 32'(frame_done), 32'(1'b0));
      rst_n = 1'b1;

      // Frame 1 dark; frame 2 shows 1234 (digit 0 is the low nibble).
      check_frame({4{7'h7F}}, 4'h0, 4'hF);
      digits = 16'h0000;
      check_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF);

      // Mid-frame change during slot 1 is not visible until the next frame.
      check_span(0, 5, {4{7'h40}}, 4'hF, 4'hF);
      digits = 16'hFFFF;
      check_span(6, 15, {4{7'h40}}, 4'hF, 4'hF);

      exp_segs = {4{7'h0E}};
      exp_dpn  = 4'hF;
      for (int v = 0; v < 16; v++) begin
         logic [3:0] nv;
         nv     = 4'(v);
         digits = {12'h000, nv};
         dp     = {3'b000, nv[0]};
         check_frame(exp_segs, 4'hF, exp_dpn);
         exp_segs = {7'h40, 7'h40, 7'h40, dec_tab[v]};
         exp_dpn  = {3'b111, ~nv[0]};
      end

      digits = 16'h8888;
      dp     = 4'h0;
      blank  = 4'b0010;
      blink  = 4'b0100;
      check_frame(exp_segs, 4'hF, exp_dpn);
      for (int f = 0; f < 6; f++)
         check_frame({4{7'h00}}, blink_lit[f], 4'hF);

      for (int f = 0; f < 1000; f++) begin
         digits = 16'($urandom);
         dp     = 4'($urandom);
         blank  = 4'($urandom);
         blink  = 4'($urandom);
         for (int k = 0; k < 16; k++) begin
            tick();
            check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
            if ((k % 4) == 0)
               check("an_deadtime", 32'(an), 32'(4'hF));
         end
      end

      digits = 16'h8888;
      dp     = 4'h0;
      blank  = 4'h0;
      blink  = 4'h0;
      for (int k = 0; k < 16; k++) begin
         tick();
         check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      end
      check_span(0, 9, {4{7'h00}}, 4'hF, 4'hF);
      rst_n = 1'b0;
      #1;
      check("async_an",    32'(an),         32'(4'hF));
      check("async_seg",   32'(seg),        32'(7'h7F));
      check("async_dp",    32'(seg_dp),     32'(1'b1));
      check("async_fdone", 32'(frame_done), 32'(1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_frame({4{7'h7F}}, 4'h0, 4'hF);
      check_frame({4{7'h00}}, 4'hF, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
